// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issues decoded operations to an external combinational ALU
// and returns a registered writeback / branch record on a valid/ready handshake.
// Operand and operation outputs come only from registers, so the ALU path
// starts at a flop. The ALU result is captured at the end of the single EXEC cycle.
module alu_issue_seq #(
    parameter int REG_ADDR_W = 5,
    parameter int MASK_SHAMT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [31:0]           in_rs,
    input  logic [31:0]           in_rt,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic [31:0]           alu_data1,
    output logic [31:0]           alu_data2,
    output logic [2:0]            alu_operation,
    input  logic [31:0]           alu_result,
    input  logic                  alu_zero,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [31:0]           wb_result,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_we,
    output logic                  br_taken,
    output logic                  illegal
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_BEQ = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;

    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    // Decoded-op to ALU control code; branches compare by subtraction.
    function automatic logic [2:0] map_op(input logic [3:0] op);
        logic [2:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_OR:   code = ALU_OR;
            OP_AND:  code = ALU_AND;
            OP_SLL:  code = ALU_SLL;
            OP_BEQ:  code = ALU_SUB;
            OP_BNE:  code = ALU_SUB;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op > OP_BNE);
    endfunction

    logic [1:0]            state_q,     state_d;
    logic [31:0]           data1_q,     data1_d;
    logic [31:0]           data2_q,     data2_d;
    logic [2:0]            aop_q,       aop_d;
    logic [3:0]            op_q,        op_d;
    logic [REG_ADDR_W-1:0] rd_q,        rd_d;
    logic                  wb_valid_q,  wb_valid_d;
    logic [31:0]           wb_result_q, wb_result_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,     wb_rd_d;
    logic                  wb_we_q,     wb_we_d;
    logic                  br_taken_q,  br_taken_d;
    logic                  illegal_q,   illegal_d;
    logic                  in_ready_s;
    logic                  accept_s;

    // Request acceptance: free when idle, or when the held record drains this cycle.
    always_comb begin
        in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_WB) && wb_ready);
        accept_s   = in_valid && in_ready_s;
    end

    // Next-state, operand loading and result capture.
    always_comb begin
        state_d     = state_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        aop_d       = aop_q;
        op_d        = op_q;
        rd_d        = rd_q;
        wb_valid_d  = wb_valid_q;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = wb_we_q;
        br_taken_d  = br_taken_q;
        illegal_d   = illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d     = ST_WB;
                wb_valid_d  = 1'b1;
                wb_rd_d     = rd_q;
                illegal_d   = op_is_illegal(op_q);
                if (op_is_illegal(op_q)) begin
                    wb_result_d = 32'd0;
                end else begin
                    wb_result_d = alu_result;
                end
                wb_we_d = (op_q <= OP_SLL) && (rd_q != {REG_ADDR_W{1'b0}});
                if (op_q == OP_BEQ) begin
                    br_taken_d = alu_zero;
                end else if (op_q == OP_BNE) begin
                    br_taken_d = ~alu_zero;
                end else begin
                    br_taken_d = 1'b0;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    if (accept_s) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WB;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wb_valid_d = 1'b0;
            end
        endcase

        // Accept only happens in IDLE or draining WB, so this never collides with EXEC capture.
        if (accept_s) begin
            op_d  = in_op;
            rd_d  = in_rd;
            aop_d = map_op(in_op);
            if (op_is_illegal(in_op)) begin
                data1_d = 32'd0;
                data2_d = 32'd0;
            end else if ((in_op == OP_SLL) && (MASK_SHAMT != 0)) begin
                data1_d = in_rs;
                data2_d = {27'd0, in_rt[4:0]};
            end else begin
                data1_d = in_rs;
                data2_d = in_rt;
            end
        end else begin
            op_d = op_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            data1_q     <= 32'd0;
            data2_q     <= 32'd0;
            aop_q       <= ALU_ADD;
            op_q        <= OP_ADD;
            rd_q        <= {REG_ADDR_W{1'b0}};
            wb_valid_q  <= 1'b0;
            wb_result_q <= 32'd0;
            wb_rd_q     <= {REG_ADDR_W{1'b0}};
            wb_we_q     <= 1'b0;
            br_taken_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            aop_q       <= aop_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            br_taken_q  <= br_taken_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready      = in_ready_s;
    assign alu_data1     = data1_q;
    assign alu_data2     = data2_q;
    assign alu_operation = aop_q;
    assign wb_valid      = wb_valid_q;
    assign wb_result     = wb_result_q;
    assign wb_rd         = wb_rd_q;
    assign wb_we         = wb_we_q;
    assign br_taken      = br_taken_q;
    assign illegal       = illegal_q;

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Initiator side of the ALU operand/operation interface: accepts decoded operations on a valid/ready handshake and drives data1/data2/aluoperation into the combinational ALU.
- Captures the ALU's result and zero outputs and presents a registered writeback/branch record on a second valid/ready handshake.
- Sits between decode and the register-file writeback / PC-select logic of the core.

Parameters:
- REG_ADDR_W, 5, width of destination register index.
- MASK_SHAMT, 1, when 1, SLL drives alu_data2 = {27'b0, rt[4:0]}; when 0, rt is passed unmasked.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_op  input  4  operation: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 SLL, 5 BEQ, 6 BNE; 7-15 illegal.
- in_rs  input  32  first operand.
- in_rt  input  32  second operand.
- in_rd  input  REG_ADDR_W  destination register index.
- alu_data1  output  32  to ALU data1.
- alu_data2  output  32  to ALU data2.
- alu_operation  output  3  to ALU: ADD 011, SUB 100, OR 101, AND 110, SLL 111.
- alu_result  input  32  from ALU result.
- alu_zero  input  1  from ALU zero.
- wb_valid  output  1  writeback record valid.
- wb_ready  input  1  consumer accepts the record.
- wb_result  output  32  captured ALU result.
- wb_rd  output  REG_ADDR_W  destination index.
- wb_we  output  1  register write enable.
- br_taken  output  1  branch decision.
- illegal  output  1  request carried an illegal op.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - alu_data1 = 0, alu_data2 = 0, alu_operation = 011.
  - wb_valid = 0, wb_result = 0, wb_rd = 0, wb_we = 0, br_taken = 0, illegal = 0.
- FSM states: IDLE, EXEC, WB.
- in_ready = (state==IDLE) | (state==WB & wb_ready). It is combinational and never depends on in_valid.
- Accept = in_valid & in_ready at a rising edge. On accept:
  - Operand registers load in_rs and in_rt; SLL masking is applied here.
  - alu_operation loads the mapped code.
  - op and rd are latched; state goes to EXEC.
- Op mapping:
  - BEQ and BNE map to SUB (100).
  - Illegal ops load operands 0 and operation 011.
- alu_data1, alu_data2 and alu_operation are driven only from these registers (no combinational path from in_*). They hold their last values when no new request is accepted.
- EXEC lasts exactly 1 cycle. At its closing edge, capture:
  - wb_result = alu_result; illegal op forces wb_result = 0.
  - wb_rd = latched rd.
  - wb_we = 1 for ADD/SUB/OR/AND/SLL with rd != 0; else 0 (rd 0 is never written; branches and illegal never write).
  - br_taken = alu_zero for BEQ, ~alu_zero for BNE, 0 otherwise.
  - illegal = 1 only for ops 7-15.
  - State goes to WB.
- WB:
  - wb_valid = 1 and all wb_* fields are held stable until wb_ready.
  - On wb_valid & wb_ready, with no new accept: state goes to IDLE and wb_valid = 0 next cycle. wb_* data fields may hold their values.
  - On wb_valid & wb_ready with a simultaneous accept: state goes to EXEC, so wb_valid = 0 for exactly one cycle.
- Latency: request accepted at edge E0 gives wb_valid = 1 after E0+2 edges. Max throughput is one op per 2 cycles.
- Width rules:
  - All arithmetic is done in the ALU, modulo 2^32; the block does not detect carry or overflow.
  - SUB result 0 gives wb_result 0.
- Boundary conditions:
  - in_valid while in EXEC, or in WB without wb_ready: in_ready = 0; the request is not consumed and the inputs are ignored.
  - in_valid may drop without the request being accepted.
  - Reset in EXEC or WB drops the pending op. Next cycle: wb_valid = 0, state IDLE, all outputs at reset values.
  - wb_ready asserted while not in WB: no effect.

Test Plan:
- ADD rs=5, rt=7, rd=3 → alu_operation 011, wb_valid 2 edges after accept, wb_result 12, wb_we 1, wb_rd 3, br_taken 0.
- BEQ rs=rt=0x1234 → alu_operation 100, wb_result 0, br_taken 1, wb_we 0. Repeat with BNE → br_taken 0. BNE rs=1, rt=2 → br_taken 1, wb_result 0xFFFFFFFF.
- SLL rs=1, rt=0x24 with MASK_SHAMT=1 → alu_data2 4, wb_result 16. ADD with rd=0 → wb_we 0. op=9 → illegal 1, wb_result 0, wb_we 0.
- Backpressure: hold wb_ready=0 for 5 cycles with in_valid=1 → in_ready 0, wb_* stable. Then raise wb_ready → new request accepted on the same edge, wb_valid low exactly 1 cycle.
- Stream of 4 ADDs with wb_ready=1 → one result every 2 cycles, in order, correct values (1+1, 2+2, 0xFFFFFFFF+1=0, 3+4).
- Assert reset during EXEC and during WB → next cycle wb_valid 0, alu_operation 011, alu_data1/2 0, in_ready 1, and no stale record appears afterwards.
